pipelined_mac_array: RTL



---
 rtl/pipelined_mac_array.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipelined_mac_array.sv
// rtl/pipelined_mac_array.sv - pipelined multi-lane signed multiplier / MAC with valid/ready flow control
// Input register, PIPE product stages, then an output stage holding the per-lane accumulators.
module pipelined_mac_array #(
  parameter int LANES = 3,
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic                   last,
  input  logic [LANES*WIDTH-1:0] op_a,
  input  logic [LANES*WIDTH-1:0] op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int LS = PIPE - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic                   in_v_q;
  logic                   in_mode_q;
  logic                   in_last_q;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      in_v_q    <= 1'b0;
      in_mode_q <= 1'b0;
      in_last_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else if (!stall) begin
      in_v_q    <= in_valid;
      in_mode_q <= mode;
      in_last_q <= last;
      a_q       <= op_a;
      b_q       <= op_b;
    end
  end

  logic signed [PW-1:0] prod [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PW'($signed(a_q[k*WIDTH +: WIDTH])) * PW'($signed(b_q[k*WIDTH +: WIDTH]));
    end
  end

  logic                 st_v    [PIPE];
  logic                 st_mode [PIPE];
  logic                 st_last [PIPE];
  logic signed [PW-1:0] st_p    [PIPE][LANES];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int s = 0; s < PIPE; s++) begin
        st_v[s]    <= 1'b0;
        st_mode[s] <= 1'b0;
        st_last[s] <= 1'b0;
        for (int k = 0; k < LANES; k++) st_p[s][k] <= '0;
      end
    end else if (!stall) begin
      st_v[0]    <= in_v_q;
      st_mode[0] <= in_mode_q;
      st_last[0] <= in_last_q;
      for (int k = 0; k < LANES; k++) st_p[0][k] <= prod[k];
      for (int s = 1; s < PIPE; s++) begin
        st_v[s]    <= st_v[s-1];
        st_mode[s] <= st_mode[s-1];
        st_last[s] <= st_last[s-1];
        for (int k = 0; k < LANES; k++) st_p[s][k] <= st_p[s-1][k];
      end
    end
  end

  logic signed [PW-1:0]    acc     [LANES];
  logic signed [PW-1:0]    sum     [LANES];
  logic        [WIDTH-1:0] sat_val [LANES];
  logic                    sat_hit [LANES];

  // The sum fits in WIDTH bits only when its top WIDTH+1 bits are a pure sign extension.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sum[k]     = acc[k] + st_p[LS][k];
      sat_hit[k] = !((sum[k][PW-1:WIDTH-1] == '0) || (sum[k][PW-1:WIDTH-1] == '1));
      sat_val[k] = sum[k][WIDTH-1:0];
      if (sat_hit[k]) sat_val[k] = sum[k][PW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= '0;
      for (int k = 0; k < LANES; k++) acc[k] <= '0;
    end else if (!stall) begin
      out_valid <= st_v[LS] && (!st_mode[LS] || st_last[LS]);
      if (st_v[LS]) begin
        for (int k = 0; k < LANES; k++) begin
          if (!st_mode[LS]) begin
            result[k*WIDTH +: WIDTH] <= st_p[LS][k][WIDTH-1:0];
            overflow[k]              <= 1'b0;
          end else if (st_last[LS]) begin
            result[k*WIDTH +: WIDTH] <= sat_val[k];
            overflow[k]              <= sat_hit[k];
            acc[k]                   <= '0;
          end else begin
            acc[k] <= sum[k];
          end
        end
      end
    end
  end

endmodule
